// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
//   Shares the single RAM port between the SPI command stream and a local host
//   port. SPI words are decoded on the rising edge of spi_rx_valid: 00/10 load
//   the write/read address registers, 01/11 queue a RAM write/read in a
//   one-entry pending slot. A three-state FSM (IDLE/ACC/RET) issues one access
//   at a time. SPI has priority, but a starvation counter forces the host
//   through after STARVE_LIMIT contested SPI wins.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   spi_rx_data[9:0]              SPI word: [9:8] cmd, [7:0] addr/data
//   spi_rx_valid                  level from SPI slave, word taken on 0->1
//   spi_tx_data[7:0]              SPI read data
//   spi_tx_valid                  held from read return until next rx edge
//   host_req/we/addr/wdata        host request, held until host_gnt
//   host_gnt                      1-cycle pulse, host access on RAM this cycle
//   host_rdata/host_rvalid        host read data with 1-cycle valid pulse
//   ram_en/we/addr/wdata          RAM access strobe and command
//   ram_rdata                     RAM read data, valid cycle after read strobe
//   spi_ovf                       sticky: SPI RAM command dropped
module spi_ram_arbiter #(
    parameter int MEM_DEPTH    = 256,
    parameter int ADDR_SIZE    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           spi_rx_data,
    input  logic                 spi_rx_valid,
    output logic [7:0]           spi_tx_data,
    output logic                 spi_tx_valid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [7:0]           host_wdata,
    output logic                 host_gnt,
    output logic [7:0]           host_rdata,
    output logic                 host_rvalid,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [7:0]           ram_wdata,
    input  logic [7:0]           ram_rdata,
    output logic                 spi_ovf
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    if (MEM_DEPTH > (1 << ADDR_SIZE)) begin : g_depth_check
        $error("MEM_DEPTH exceeds the range of ADDR_SIZE");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        RET
    } state_t;

    state_t state, state_nxt;

    logic                 rx_q;
    logic                 rx_edge;
    logic [1:0]           cmd;
    logic [ADDR_SIZE-1:0] word_addr;
    logic [7:0]           word_data;
    logic                 capture;

    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;

    logic                 pend_vld;
    logic                 pend_we;
    logic [ADDR_SIZE-1:0] pend_addr;
    logic [7:0]           pend_data;

    logic                 src_host;
    logic [CNT_W-1:0]     starve_cnt;

    logic                 spi_win;
    logic                 host_win;

    assign rx_edge   = spi_rx_valid & ~rx_q;
    assign cmd       = spi_rx_data[9:8];
    assign word_addr = spi_rx_data[ADDR_SIZE-1:0];
    assign word_data = spi_rx_data[7:0];
    // cmd[0] set means the word needs a RAM slot (01 write, 11 read)
    assign capture   = rx_edge & cmd[0];

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- arbitration and next state ----------------
    always_comb begin
        spi_win   = 1'b0;
        host_win  = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pend_vld && host_req) begin
                    if (starve_cnt == STARVE_MAX) begin
                        host_win = 1'b1;
                    end else begin
                        spi_win = 1'b1;
                    end
                end else if (pend_vld) begin
                    spi_win = 1'b1;
                end else if (host_req) begin
                    host_win = 1'b1;
                end
                if (spi_win || host_win) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                state_nxt = ram_we ? IDLE : RET;
            end
            RET: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------- SPI decode and pending slot ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q      <= 1'b0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            pend_vld  <= 1'b0;
            pend_we   <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            spi_ovf   <= 1'b0;
        end else begin
            rx_q <= spi_rx_valid;
            if (rx_edge && cmd == 2'b00) begin
                wr_addr <= word_addr;
            end
            if (rx_edge && cmd == 2'b10) begin
                rd_addr <= word_addr;
            end
            // The slot counts as full for the whole IDLE cycle in which it is
            // being issued; it is released only as the access enters ACC.
            if (capture && pend_vld) begin
                spi_ovf <= 1'b1;
            end else if (capture) begin
                pend_vld  <= 1'b1;
                pend_we   <= ~cmd[1];
                pend_addr <= cmd[1] ? rd_addr : wr_addr;
                pend_data <= word_data;
            end else if (spi_win) begin
                pend_vld <= 1'b0;
            end
        end
    end

    // ---------------- starvation counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (host_win) begin
            starve_cnt <= '0;
        end else if (spi_win && host_req && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // ---------------- RAM command and returned data ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            host_gnt     <= 1'b0;
            src_host     <= 1'b0;
            host_rdata   <= '0;
            host_rvalid  <= 1'b0;
            spi_tx_data  <= '0;
            spi_tx_valid <= 1'b0;
        end else begin
            // Registered from the IDLE decision, so ram_en/host_gnt are high
            // exactly during ACC.
            ram_en   <= spi_win | host_win;
            host_gnt <= host_win;
            if (host_win) begin
                ram_we    <= host_we;
                ram_addr  <= host_addr;
                ram_wdata <= host_wdata;
                src_host  <= 1'b1;
            end else if (spi_win) begin
                ram_we    <= pend_we;
                ram_addr  <= pend_addr;
                ram_wdata <= pend_data;
                src_host  <= 1'b0;
            end

            host_rvalid <= (state == RET) && src_host;
            if (state == RET && src_host) begin
                host_rdata <= ram_rdata;
            end

            // A read return in the same cycle as a new rx edge keeps the fresh data.
            if (state == RET && !src_host) begin
                spi_tx_data  <= ram_rdata;
                spi_tx_valid <= 1'b1;
            end else if (rx_edge) begin
                spi_tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] spi_rx_data = '0;
    logic       spi_rx_valid = 1'b0;
    logic [7:0] spi_tx_data;
    logic       spi_tx_valid;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [7:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic       host_gnt;
    logic [7:0] host_rdata;
    logic       host_rvalid;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = '0;
    logic       spi_ovf;

    spi_ram_arbiter #(
        .MEM_DEPTH   (256),
        .ADDR_SIZE   (8),
        .STARVE_LIMIT(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_rx_data (spi_rx_data),
        .spi_rx_valid(spi_rx_valid),
        .spi_tx_data (spi_tx_data),
        .spi_tx_valid(spi_tx_valid),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .spi_ovf     (spi_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External single-port RAM
    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    end

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         at;
    } ram_exp_t;

    typedef struct {
        logic [7:0] data;
        int         at;
    } rd_exp_t;

    ram_exp_t ram_q[$];
    rd_exp_t  spi_q[$];
    rd_exp_t  host_q[$];
    int       gnt_q[$];

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_ram(input logic we, input logic [7:0] a, input logic [7:0] d, input int at);
        ram_exp_t e;
        e.we = we; e.addr = a; e.wdata = d; e.at = at;
        ram_q.push_back(e);
    endtask

    task automatic exp_spi(input logic [7:0] d, input int at);
        rd_exp_t e;
        e.data = d; e.at = at;
        spi_q.push_back(e);
    endtask

    task automatic exp_host(input logic [7:0] d, input int at);
        rd_exp_t e;
        e.data = d; e.at = at;
        host_q.push_back(e);
    endtask

    task automatic send_word(input logic [1:0] c, input logic [7:0] d);
        spi_rx_data  = {c, d};
        spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
        tick();
    endtask

    task automatic wait_gnt(input string name);
        int i = 0;
        while (!host_gnt && i < 16) begin
            tick();
            i++;
        end
        if (!host_gnt) begin
            total++;
            bad++;
            $display("FAIL %s: host_gnt not seen within 16 cycles (cycle %0d)", name, cyc);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({spi_tx_data, spi_tx_valid, host_gnt, host_rdata, host_rvalid,
                    ram_en, ram_we, ram_addr, ram_wdata, spi_ovf});
    endfunction

    // Monitor: pops expectations whenever the DUT presents an output event
    ram_exp_t re;
    rd_exp_t  de;
    int       ge;
    logic     tx_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (ram_en) begin
                total++;
                if (ram_q.size() == 0) begin
                    bad++;
                    $display("FAIL ram_access: unexpected we=%0d addr=%h wdata=%h at cycle %0d",
                             ram_we, ram_addr, ram_wdata, cyc);
                end else begin
                    re = ram_q.pop_front();
                    if (ram_we !== re.we || ram_addr !== re.addr ||
                        (re.we && ram_wdata !== re.wdata) || cyc != re.at) begin
                        bad++;
                        $display("FAIL ram_access: got we=%0d addr=%h wdata=%h cycle=%0d, want we=%0d addr=%h wdata=%h cycle=%0d",
                                 ram_we, ram_addr, ram_wdata, cyc, re.we, re.addr, re.wdata, re.at);
                    end
                end
            end
            if (host_gnt) begin
                total++;
                if (gnt_q.size() == 0) begin
                    bad++;
                    $display("FAIL host_gnt: unexpected grant at cycle %0d", cyc);
                end else begin
                    ge = gnt_q.pop_front();
                    if (cyc != ge) begin
                        bad++;
                        $display("FAIL host_gnt: got cycle %0d, want cycle %0d", cyc, ge);
                    end
                end
            end
            if (host_rvalid) begin
                total++;
                if (host_q.size() == 0) begin
                    bad++;
                    $display("FAIL host_rvalid: unexpected data %h at cycle %0d", host_rdata, cyc);
                end else begin
                    de = host_q.pop_front();
                    if (host_rdata !== de.data || cyc != de.at) begin
                        bad++;
                        $display("FAIL host_rvalid: got data=%h cycle=%0d, want data=%h cycle=%0d",
                                 host_rdata, cyc, de.data, de.at);
                    end
                end
            end
            if (spi_tx_valid && !tx_prev) begin
                total++;
                if (spi_q.size() == 0) begin
                    bad++;
                    $display("FAIL spi_tx_valid: unexpected data %h at cycle %0d", spi_tx_data, cyc);
                end else begin
                    de = spi_q.pop_front();
                    if (spi_tx_data !== de.data || cyc != de.at) begin
                        bad++;
                        $display("FAIL spi_tx_valid: got data=%h cycle=%0d, want data=%h cycle=%0d",
                                 spi_tx_data, cyc, de.data, de.at);
                    end
                end
            end
            tx_prev = spi_tx_valid;
        end
    end

    // Host held high against back-to-back SPI writes to 0x40: four SPI writes,
    // then the host write, then the fifth SPI write.
    task automatic starve_round(input logic [7:0] base, input logic [7:0] ha, input logic [7:0] hd);
        int e0;
        e0 = cyc;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                exp_ram(1'b1, ha, hd, e0 + 10);
                gnt_q.push_back(e0 + 10);
                exp_ram(1'b1, 8'h40, 8'(base + 8'(k)), e0 + 12);
            end else begin
                exp_ram(1'b1, 8'h40, 8'(base + 8'(k)), e0 + 2 + 2 * k);
            end
            spi_rx_data  = {2'b01, 8'(base + 8'(k))};
            spi_rx_valid = 1'b1;
            tick();
            spi_rx_valid = 1'b0;
            if (k == 0) begin
                host_req   = 1'b1;
                host_we    = 1'b1;
                host_addr  = ha;
                host_wdata = hd;
            end
            tick();
        end
        wait_gnt("starve_gnt");
        host_req = 1'b0;
        repeat (4) tick();
    endtask

    int n;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h33] = 8'h69;
        mem[8'h00] = 8'hC3;

        // Reset state
        repeat (3) tick();
        chk("reset_outputs", all_outs(), 64'h0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_outputs", all_outs(), 64'h0);

        // SPI write: wr_addr=0x12, data 0xA5
        send_word(2'b00, 8'h12);
        n = cyc;
        exp_ram(1'b1, 8'h12, 8'hA5, n + 2);
        send_word(2'b01, 8'hA5);
        repeat (2) tick();
        chk("no_tx_after_write", 64'(spi_tx_valid), 64'h0);

        // SPI read back of 0x12
        send_word(2'b10, 8'h12);
        n = cyc;
        exp_ram(1'b0, 8'h12, 8'h00, n + 2);
        exp_spi(8'hA5, n + 4);
        send_word(2'b11, 8'h00);
        repeat (3) tick();
        chk("tx_valid_held", 64'(spi_tx_valid), 64'h1);
        chk("tx_data_held", 64'(spi_tx_data), 64'hA5);
        send_word(2'b00, 8'h40);
        chk("tx_valid_drop", 64'(spi_tx_valid), 64'h0);

        // Host read of 0x33
        repeat (2) tick();
        n = cyc;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 8'h33;
        exp_ram(1'b0, 8'h33, 8'h00, n + 1);
        gnt_q.push_back(n + 1);
        exp_host(8'h69, n + 3);
        tick();
        wait_gnt("host_read_gnt");
        host_req = 1'b0;
        repeat (4) tick();

        // Starvation: second round only matches if the counter cleared on grant
        starve_round(8'h50, 8'h41, 8'h77);
        starve_round(8'h60, 8'h42, 8'h88);
        chk("ovf_still_clear", 64'(spi_ovf), 64'h0);

        // Overflow: two 01 words while the first waits behind a host read
        repeat (2) tick();
        n = cyc;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 8'h33;
        exp_ram(1'b0, 8'h33, 8'h00, n + 1);
        gnt_q.push_back(n + 1);
        exp_host(8'h69, n + 3);
        exp_ram(1'b1, 8'h40, 8'h11, n + 4);
        spi_rx_data  = {2'b01, 8'h11};
        spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
        host_req     = 1'b0;
        tick();
        spi_rx_data  = {2'b01, 8'h22};
        spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
        repeat (4) tick();
        chk("ovf_set", 64'(spi_ovf), 64'h1);

        // Reset during RET of an SPI read
        n = cyc;
        exp_ram(1'b0, 8'h12, 8'h00, n + 2);
        send_word(2'b11, 8'h00);
        tick();
        rst_n = 1'b0;
        #1;
        chk("reset_in_ret", all_outs(), 64'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("quiet_after_reset", all_outs(), 64'h0);

        // Read after reset uses rd_addr=0
        n = cyc;
        exp_ram(1'b0, 8'h00, 8'h00, n + 2);
        exp_spi(8'hC3, n + 4);
        send_word(2'b11, 8'h00);
        repeat (6) tick();
        chk("read_after_reset_valid", 64'(spi_tx_valid), 64'h1);

        chk("ram_q_empty", 64'(ram_q.size()), 64'h0);
        chk("spi_q_empty", 64'(spi_q.size()), 64'h0);
        chk("host_q_empty", 64'(host_q.size()), 64'h0);
        chk("gnt_q_empty", 64'(gnt_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
